// File: rtl/store_data_packer.sv
// Store data packer: narrows a register value to a byte/half/word memory write with lane-positioned data and byte enables.
// Optional feature macro MISALIGNED_SPLIT_EN: misaligned stores become one or two beats instead of being rejected.
module store_data_packer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  reqValid_i,
    output logic                  reqReady_o,
    input  logic [ADDR_WIDTH-1:0] reqAddr_i,
    input  logic [31:0]           reqData_i,
    input  logic [1:0]            reqSize_i,
    output logic                  memValid_o,
    input  logic                  memReady_i,
    output logic [ADDR_WIDTH-1:0] memAddr_o,
    output logic [31:0]           memData_o,
    output logic [3:0]            memByteEn_o,
    output logic                  error_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t                state_q;
    logic                  memValid_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [31:0]           memData_q;
    logic [3:0]            memByteEn_q;
    logic                  error_q;
    logic                  twoBeat_q;
    logic [ADDR_WIDTH-1:0] beat1Addr_q;
    logic [31:0]           beat1Data_q;
    logic [3:0]            beat1ByteEn_q;

    logic [1:0]            off;
    logic [2:0]            nBytes;
    logic [31:0]           sizeMask;
    logic [3:0]            laneMask;
    logic                  aligned;
    logic                  reserved;
    logic                  crossing;
    logic                  reject_d;
    logic                  twoBeat_d;
    logic [63:0]           wideData_d;
    logic [7:0]            wideEn_d;
    logic [ADDR_WIDTH-1:0] baseAddr_d;
    logic [ADDR_WIDTH-1:0] nextAddr_d;

    // Shifting into a double-width window gives beat0 in the low half and the spill-over beat1 in the high half.
    always_comb begin
        off        = reqAddr_i[1:0];
        nBytes     = 3'd4;
        sizeMask   = 32'hFFFF_FFFF;
        laneMask   = 4'b1111;
        aligned    = 1'b0;
        reserved   = 1'b0;
        case (reqSize_i)
            2'b00: begin
                nBytes   = 3'd1;
                sizeMask = 32'h0000_00FF;
                laneMask = 4'b0001;
                aligned  = 1'b1;
            end
            2'b01: begin
                nBytes   = 3'd2;
                sizeMask = 32'h0000_FFFF;
                laneMask = 4'b0011;
                aligned  = ~off[0];
            end
            2'b10: begin
                aligned  = (off == 2'b00);
            end
            default: begin
                reserved = 1'b1;
            end
        endcase
        crossing   = (({1'b0, off} + nBytes) > 3'd4);
`ifdef MISALIGNED_SPLIT_EN
        reject_d   = reserved;
`else
        reject_d   = reserved | ~aligned;
`endif
        twoBeat_d  = crossing & ~reject_d;
        wideData_d = {32'h0, reqData_i & sizeMask} << {off, 3'b000};
        wideEn_d   = {4'h0, laneMask} << off;
        baseAddr_d = {reqAddr_i[ADDR_WIDTH-1:2], 2'b00};
        nextAddr_d = baseAddr_d + ADDR_WIDTH'(4);
    end

    // Control FSM; every memory-side output is a register so beats stay stable while stalled.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            memValid_q    <= 1'b0;
            memAddr_q     <= '0;
            memData_q     <= '0;
            memByteEn_q   <= '0;
            error_q       <= 1'b0;
            twoBeat_q     <= 1'b0;
            beat1Addr_q   <= '0;
            beat1Data_q   <= '0;
            beat1ByteEn_q <= '0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (reqValid_i) begin
                        if (reject_d) begin
                            error_q <= 1'b1;
                        end else begin
                            memValid_q    <= 1'b1;
                            memAddr_q     <= baseAddr_d;
                            memData_q     <= wideData_d[31:0];
                            memByteEn_q   <= wideEn_d[3:0];
                            twoBeat_q     <= twoBeat_d;
                            beat1Addr_q   <= nextAddr_d;
                            beat1Data_q   <= wideData_d[63:32];
                            beat1ByteEn_q <= wideEn_d[7:4];
                            state_q       <= BEAT0;
                        end
                    end
                end
                BEAT0: begin
                    if (memReady_i) begin
                        if (twoBeat_q) begin
                            memAddr_q   <= beat1Addr_q;
                            memData_q   <= beat1Data_q;
                            memByteEn_q <= beat1ByteEn_q;
                            state_q     <= BEAT1;
                        end else begin
                            memValid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                BEAT1: begin
                    if (memReady_i) begin
                        memValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    memValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so the upstream never sees a handshake during reset.
    assign reqReady_o  = (state_q == IDLE) && !reset_i;
    assign memValid_o  = memValid_q;
    assign memAddr_o   = memAddr_q;
    assign memData_o   = memData_q;
    assign memByteEn_o = memByteEn_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_store_data_packer.sv
// Directed bench for store_data_packer; expectations follow MISALIGNED_SPLIT_EN when it is defined.
module tb_store_data_packer;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        reqValid_i = 1'b0;
    logic        reqReady_o;
    logic [31:0] reqAddr_i = '0;
    logic [31:0] reqData_i = '0;
    logic [1:0]  reqSize_i = '0;
    logic        memValid_o;
    logic        memReady_i = 1'b0;
    logic [31:0] memAddr_o;
    logic [31:0] memData_o;
    logic [3:0]  memByteEn_o;
    logic        error_o;

    int assertCount = 0;
    int failCount   = 0;

    wire [69:0] observedBeat = {memValid_o, memAddr_o, memData_o, memByteEn_o, error_o};

    always #5 clk_i = ~clk_i;

    store_data_packer #(.ADDR_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .reqValid_i  (reqValid_i),
        .reqReady_o  (reqReady_o),
        .reqAddr_i   (reqAddr_i),
        .reqData_i   (reqData_i),
        .reqSize_i   (reqSize_i),
        .memValid_o  (memValid_o),
        .memReady_i  (memReady_i),
        .memAddr_o   (memAddr_o),
        .memData_o   (memData_o),
        .memByteEn_o (memByteEn_o),
        .error_o     (error_o)
    );

    // Presents one request, waits (bounded) for ready, and returns at the negedge of cycle N+1.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        int waitCycles = 0;
        reqAddr_i  = addr;
        reqData_i  = data;
        reqSize_i  = size;
        reqValid_i = 1'b1;
        while (!reqReady_o && waitCycles < 8) begin
            @(negedge clk_i);
            waitCycles++;
        end
        assertCount++;
        if (reqReady_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL accept_wait: reqReady got %b required 1", reqReady_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        reqValid_i = 1'b0;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        assertCount++;
        if ({observedBeat, reqReady_o} !== 71'h0) begin
            failCount++;
            $display("[TB] FAIL reset_state: got %h/%b required 0/0", observedBeat, reqReady_o);
        end
        reset_i = 1'b0;
        #1;
        assertCount++;
        if (reqReady_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_release_ready: got %b required 1", reqReady_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_byte;
        memReady_i = 1'b1;
        applyStimulus(32'h0000_0103, 32'hAABB_CCDD, 2'b00);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0100, 32'hDD00_0000, 4'b1000, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL byte_off3_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0100, 32'hDD00_0000, 4'b1000, 1'b0});
        end
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, reqReady_o} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL byte_done: valid/ready got %b required 01", {memValid_o, reqReady_o});
        end
        applyStimulus(32'h0000_0021, 32'h0000_00AB, 2'b00);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL byte_off1_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 1'b0});
        end
        @(negedge clk_i);
    endtask

    task automatic test_half;
        memReady_i = 1'b1;
        applyStimulus(32'h0000_0102, 32'h1234_BEEF, 2'b01);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0100, 32'hBEEF_0000, 4'b1100, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL half_off2_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0100, 32'hBEEF_0000, 4'b1100, 1'b0});
        end
        @(negedge clk_i);
        applyStimulus(32'h0000_0010, 32'hFFFF_5678, 2'b01);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0010, 32'h0000_5678, 4'b0011, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL half_off0_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0010, 32'h0000_5678, 4'b0011, 1'b0});
        end
        @(negedge clk_i);
        applyStimulus(32'h0000_0040, 32'hCAFE_BABE, 2'b10);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0040, 32'hCAFE_BABE, 4'b1111, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL word_aligned_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0040, 32'hCAFE_BABE, 4'b1111, 1'b0});
        end
        @(negedge clk_i);
        applyStimulus(32'h0000_0301, 32'h0000_ABCD, 2'b01);
`ifdef MISALIGNED_SPLIT_EN
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0300, 32'h00AB_CD00, 4'b0110, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL half_off1_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0300, 32'h00AB_CD00, 4'b0110, 1'b0});
        end
`else
        assertCount++;
        if ({memValid_o, error_o} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL half_off1_reject: valid/error got %b required 01", {memValid_o, error_o});
        end
`endif
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, error_o, reqReady_o} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL half_off1_done: valid/error/ready got %b required 001", {memValid_o, error_o, reqReady_o});
        end
    endtask

    task automatic test_misaligned_word;
        memReady_i = 1'b0;
        applyStimulus(32'h0000_0201, 32'h1122_3344, 2'b10);
`ifdef MISALIGNED_SPLIT_EN
        for (int i = 0; i < 3; i++) begin
            assertCount++;
            if (observedBeat !== {1'b1, 32'h0000_0200, 32'h2233_4400, 4'b1110, 1'b0}) begin
                failCount++;
                $display("[TB] FAIL split_beat0_hold%0d: got %h required %h", i, observedBeat, {1'b1, 32'h0000_0200, 32'h2233_4400, 4'b1110, 1'b0});
            end
            if (i < 2) @(negedge clk_i);
        end
        memReady_i = 1'b1;
        @(negedge clk_i);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0204, 32'h0000_0011, 4'b0001, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL split_beat1: got %h required %h", observedBeat, {1'b1, 32'h0000_0204, 32'h0000_0011, 4'b0001, 1'b0});
        end
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, reqReady_o} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL split_done: valid/ready got %b required 01", {memValid_o, reqReady_o});
        end
`else
        assertCount++;
        if ({memValid_o, error_o, reqReady_o} !== 3'b011) begin
            failCount++;
            $display("[TB] FAIL word_off1_reject: valid/error/ready got %b required 011", {memValid_o, error_o, reqReady_o});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            assertCount++;
            if ({memValid_o, error_o} !== 2'b00) begin
                failCount++;
                $display("[TB] FAIL word_off1_quiet%0d: valid/error got %b required 00", i, {memValid_o, error_o});
            end
        end
        memReady_i = 1'b1;
`endif
    endtask

    task automatic test_wrap;
        memReady_i = 1'b1;
        applyStimulus(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'b10);
`ifdef MISALIGNED_SPLIT_EN
        assertCount++;
        if (observedBeat !== {1'b1, 32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL wrap_beat0: got %h required %h", observedBeat, {1'b1, 32'hFFFF_FFFC, 32'hC3D4_0000, 4'b1100, 1'b0});
        end
        @(negedge clk_i);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0000, 32'h0000_A1B2, 4'b0011, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL wrap_beat1: got %h required %h", observedBeat, {1'b1, 32'h0000_0000, 32'h0000_A1B2, 4'b0011, 1'b0});
        end
`else
        assertCount++;
        if ({memValid_o, error_o} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL wrap_reject: valid/error got %b required 01", {memValid_o, error_o});
        end
`endif
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, error_o, reqReady_o} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL wrap_done: valid/error/ready got %b required 001", {memValid_o, error_o, reqReady_o});
        end
    endtask

    task automatic test_reserved;
        memReady_i = 1'b1;
        applyStimulus(32'h0000_0000, 32'hDEAD_BEEF, 2'b11);
        assertCount++;
        if ({memValid_o, error_o, reqReady_o} !== 3'b011) begin
            failCount++;
            $display("[TB] FAIL reserved_error: valid/error/ready got %b required 011", {memValid_o, error_o, reqReady_o});
        end
        applyStimulus(32'h0000_0000, 32'h55AA_55AA, 2'b10);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0000, 32'h55AA_55AA, 4'b1111, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL reserved_next_beat: got %h required %h", observedBeat, {1'b1, 32'h0000_0000, 32'h55AA_55AA, 4'b1111, 1'b0});
        end
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, reqReady_o} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL reserved_next_done: valid/ready got %b required 01", {memValid_o, reqReady_o});
        end
    endtask

    task automatic test_back_to_back;
        memReady_i = 1'b1;
        applyStimulus(32'h0000_0400, 32'h0000_0077, 2'b00);
        reqAddr_i  = 32'h0000_0406;
        reqData_i  = 32'h9999_CAFE;
        reqSize_i  = 2'b01;
        reqValid_i = 1'b1;
        assertCount++;
        if ({observedBeat, reqReady_o} !== {1'b1, 32'h0000_0400, 32'h0000_0077, 4'b0001, 1'b0, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL b2b_first: got %h required %h", {observedBeat, reqReady_o}, {1'b1, 32'h0000_0400, 32'h0000_0077, 4'b0001, 1'b0, 1'b0});
        end
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, reqReady_o} !== 2'b01) begin
            failCount++;
            $display("[TB] FAIL b2b_gap: valid/ready got %b required 01", {memValid_o, reqReady_o});
        end
        @(negedge clk_i);
        reqValid_i = 1'b0;
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0404, 32'hCAFE_0000, 4'b1100, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL b2b_second: got %h required %h", observedBeat, {1'b1, 32'h0000_0404, 32'hCAFE_0000, 4'b1100, 1'b0});
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid;
`ifdef MISALIGNED_SPLIT_EN
        memReady_i = 1'b0;
        applyStimulus(32'h0000_0201, 32'h1122_3344, 2'b10);
        memReady_i = 1'b1;
        @(negedge clk_i);
        memReady_i = 1'b0;
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0204, 32'h0000_0011, 4'b0001, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL midreset_in_beat1: got %h required %h", observedBeat, {1'b1, 32'h0000_0204, 32'h0000_0011, 4'b0001, 1'b0});
        end
`else
        memReady_i = 1'b0;
        applyStimulus(32'h0000_0200, 32'h0102_0304, 2'b10);
        assertCount++;
        if (observedBeat !== {1'b1, 32'h0000_0200, 32'h0102_0304, 4'b1111, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL midreset_in_beat0: got %h required %h", observedBeat, {1'b1, 32'h0000_0200, 32'h0102_0304, 4'b1111, 1'b0});
        end
`endif
        reset_i = 1'b1;
        @(negedge clk_i);
        assertCount++;
        if ({memValid_o, reqReady_o} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL midreset_drop: valid/ready got %b required 00", {memValid_o, reqReady_o});
        end
        reset_i = 1'b0;
        #1;
        assertCount++;
        if (reqReady_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midreset_release_ready: got %b required 1", reqReady_o);
        end
        @(negedge clk_i);
        assertCount++;
        if (memValid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_stays_idle: memValid got %b required 0", memValid_o);
        end
    endtask

    // Sequences the scenarios and reports the totals.
    initial begin
        @(negedge clk_i);
        test_reset();
        test_byte();
        test_half();
        test_misaligned_word();
        test_wrap();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Guards against a hang anywhere in the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
